// File: rtl/frame_capture_if.sv
// Pixel stream plus frame-memory write port shared by the capture engine and its environment.
// master drives the stream and sinks writes; slave is the capture engine.
interface frame_capture_if #(
    parameter int PIX_W  = 8,
    parameter int CH     = 1,
    parameter int ADDR_W = 19
);
    logic                  fval;
    logic                  lval;
    logic                  dval;
    logic [CH*PIX_W-1:0]   pix_data;
    logic [ADDR_W-1:0]     mem_addr;
    logic [CH*PIX_W-1:0]   mem_data;
    logic                  mem_we;

    modport master (
        output fval, lval, dval, pix_data,
        input  mem_addr, mem_data, mem_we
    );

    modport slave (
        input  fval, lval, dval, pix_data,
        output mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/frame_capture.sv
// Frame capture engine: stores fval/lval/dval beats to frame memory and measures geometry.
// Optional FRAME_CAPTURE_SUM_EN adds a frame_sum output (sum of stored pixels).
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_IDLE     | not capturing; waits for arm or cont
// S_WAIT_LOW | armed; waits for fval low so no partial frame is taken
// S_WAIT_SOF | waits for fval to rise
// S_FRAME    | inside a frame, between lines
// S_LINE     | inside a line, accepting beats on dval
module frame_capture #(
    parameter int PIX_W  = 8,
    parameter int CH     = 1,
    parameter int MAX_W  = 640,
    parameter int MAX_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    frame_capture_if.slave     bus,
    input  logic               arm,
    input  logic               cont,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        meas_width,
    output logic [15:0]        meas_height,
    output logic               err_len,
    output logic               err_ovf
`ifdef FRAME_CAPTURE_SUM_EN
    ,
    output logic [31:0]        frame_sum
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_LOW = 3'd1;
    localparam logic [2:0] S_WAIT_SOF = 3'd2;
    localparam logic [2:0] S_FRAME    = 3'd3;
    localparam logic [2:0] S_LINE     = 3'd4;

    localparam logic [15:0]       BEATS     = 16'(MAX_W / CH);
    localparam logic [15:0]       LINES     = 16'(MAX_H);
    localparam logic [15:0]       CH_W      = 16'(CH);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(MAX_W / CH);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [2:0]        eof_state;
    logic [15:0]       beat_cnt;
    logic [15:0]       line_cnt;
    logic [15:0]       first_beats;
    logic [ADDR_W-1:0] line_base;

    logic start_cap;
    logic sof;
    logic in_frame;
    logic eof;
    logic beat_acc;
    logic line_close;
    logic in_range;
    logic do_write;

    always_comb begin
        start_cap  = (state == S_IDLE) && (arm || cont);
        sof        = (state == S_WAIT_SOF) && bus.fval;
        in_frame   = (state == S_FRAME) || (state == S_LINE);
        eof        = in_frame && !bus.fval;
        // A beat arriving together with lval's rising edge is taken in S_FRAME as beat 0.
        beat_acc   = in_frame && bus.fval && bus.lval && bus.dval;
        line_close = (state == S_LINE) && !(bus.fval && bus.lval);
        in_range   = (beat_cnt < BEATS) && (line_cnt < LINES);
        do_write   = beat_acc && in_range;
        eof_state  = cont ? S_WAIT_SOF : S_IDLE;

        state_nxt = state;
        case (state)
            S_IDLE:     if (arm || cont) state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: if (!bus.fval) state_nxt = S_WAIT_SOF;
            S_WAIT_SOF: if (bus.fval) state_nxt = S_FRAME;
            S_FRAME: begin
                if (!bus.fval)     state_nxt = eof_state;
                else if (bus.lval) state_nxt = S_LINE;
            end
            S_LINE: begin
                if (!bus.fval)      state_nxt = eof_state;
                else if (!bus.lval) state_nxt = S_FRAME;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt == S_WAIT_SOF) || (state_nxt == S_FRAME) ||
                          (state_nxt == S_LINE);
            frame_done <= eof;
            bus.mem_we <= do_write;
            if (do_write) begin
                bus.mem_addr <= line_base + ADDR_W'(beat_cnt);
                bus.mem_data <= bus.pix_data;
            end
        end
    end

    // Counters saturate so an oversized frame can never wrap back into the stored window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            line_cnt  <= '0;
            line_base <= '0;
        end else begin
            if (sof || line_close)
                beat_cnt <= '0;
            else if (beat_acc && (beat_cnt != 16'hFFFF))
                beat_cnt <= beat_cnt + 16'd1;

            if (sof) begin
                line_cnt  <= '0;
                line_base <= '0;
            end else if (line_close) begin
                if (line_cnt != 16'hFFFF)
                    line_cnt <= line_cnt + 16'd1;
                line_base <= line_base + LINE_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_width  <= '0;
            meas_height <= '0;
            first_beats <= '0;
            err_len     <= 1'b0;
            err_ovf     <= 1'b0;
        end else if (start_cap || sof) begin
            meas_width  <= '0;
            meas_height <= '0;
            first_beats <= '0;
            err_len     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            if (beat_acc && !in_range)
                err_ovf <= 1'b1;
            if (line_close) begin
                if (line_cnt == 16'd0) begin
                    meas_width  <= beat_cnt * CH_W;
                    first_beats <= beat_cnt;
                end else if (beat_cnt != first_beats) begin
                    err_len <= 1'b1;
                end
                if (meas_height != 16'hFFFF)
                    meas_height <= meas_height + 16'd1;
            end
        end
    end

`ifdef FRAME_CAPTURE_SUM_EN
    logic [31:0] beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int c = 0; c < CH; c++)
            beat_sum = beat_sum + 32'(bus.pix_data[c*PIX_W +: PIX_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_sum <= '0;
        else if (start_cap || sof)
            frame_sum <= '0;
        else if (do_write)
            frame_sum <= frame_sum + beat_sum;
    end
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Scoreboard bench for frame_capture: a CH=1 instance (8x4 window) and a CH=2 instance (8x4 window).
module tb_frame_capture;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_capture_if #(.PIX_W(8), .CH(1), .ADDR_W(5)) bus_a ();
    frame_capture_if #(.PIX_W(8), .CH(2), .ADDR_W(4)) bus_b ();

    logic        arm_a, cont_a, busy_a, fd_a, el_a, eo_a;
    logic [15:0] mw_a, mh_a;
    logic        arm_b, cont_b, busy_b, fd_b, el_b, eo_b;
    logic [15:0] mw_b, mh_b;
`ifdef FRAME_CAPTURE_SUM_EN
    logic [31:0] sum_a, sum_b;
`endif

    frame_capture #(.PIX_W(8), .CH(1), .MAX_W(8), .MAX_H(4), .ADDR_W(5)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .arm(arm_a), .cont(cont_a),
        .busy(busy_a), .frame_done(fd_a), .meas_width(mw_a), .meas_height(mh_a),
        .err_len(el_a), .err_ovf(eo_a)
`ifdef FRAME_CAPTURE_SUM_EN
        , .frame_sum(sum_a)
`endif
    );

    frame_capture #(.PIX_W(8), .CH(2), .MAX_W(8), .MAX_H(4), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .arm(arm_b), .cont(cont_b),
        .busy(busy_b), .frame_done(fd_b), .meas_width(mw_b), .meas_height(mh_b),
        .err_len(el_b), .err_ovf(eo_b)
`ifdef FRAME_CAPTURE_SUM_EN
        , .frame_sum(sum_b)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic        el;
        logic        eo;
        logic [31:0] sum;
    } fr_t;

    wr_t wq_a[$];
    wr_t wq_b[$];
    fr_t fq_a[$];
    fr_t fq_b[$];
    wr_t ea, eb;
    fr_t fa, fb;

    int n_checks   = 0;
    int n_pass     = 0;
    int fd_count_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pv(input int mode, input int l, input int b);
        if (mode == 1) begin
            case (l * 2 + b)
                0:       return 8'd1;
                1:       return 8'd2;
                2:       return 8'd3;
                default: return 8'd250;
            endcase
        end
        return 8'(l * 16 + b + 1);
    endfunction

    // Monitor: pops the expected write / frame result whenever the DUT presents one.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_a.mem_we === 1'b1) begin
                if (wq_a.size() == 0) begin
                    n_checks++;
                    $display("FAIL a_unexpected_write: addr 0x%0h data 0x%0h, none expected at %0t",
                             bus_a.mem_addr, bus_a.mem_data, $time);
                end else begin
                    ea = wq_a.pop_front();
                    chk("a_addr", 32'(bus_a.mem_addr), ea.addr);
                    chk("a_data", 32'(bus_a.mem_data), ea.data);
                end
            end
            if (fd_a === 1'b1) begin
                fd_count_a++;
                if (fq_a.size() == 0) begin
                    n_checks++;
                    $display("FAIL a_unexpected_frame_done: width %0d height %0d at %0t",
                             mw_a, mh_a, $time);
                end else begin
                    fa = fq_a.pop_front();
                    chk("a_meas_width", 32'(mw_a), 32'(fa.w));
                    chk("a_meas_height", 32'(mh_a), 32'(fa.h));
                    chk("a_err_len", 32'(el_a), 32'(fa.el));
                    chk("a_err_ovf", 32'(eo_a), 32'(fa.eo));
`ifdef FRAME_CAPTURE_SUM_EN
                    chk("a_frame_sum", sum_a, fa.sum);
`endif
                end
            end
            if (bus_b.mem_we === 1'b1) begin
                if (wq_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_unexpected_write: addr 0x%0h data 0x%0h, none expected at %0t",
                             bus_b.mem_addr, bus_b.mem_data, $time);
                end else begin
                    eb = wq_b.pop_front();
                    chk("b_addr", 32'(bus_b.mem_addr), eb.addr);
                    chk("b_data", 32'(bus_b.mem_data), eb.data);
                end
            end
            if (fd_b === 1'b1) begin
                if (fq_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_unexpected_frame_done: width %0d height %0d at %0t",
                             mw_b, mh_b, $time);
                end else begin
                    fb = fq_b.pop_front();
                    chk("b_meas_width", 32'(mw_b), 32'(fb.w));
                    chk("b_meas_height", 32'(mh_b), 32'(fb.h));
                    chk("b_err_len", 32'(el_b), 32'(fb.el));
                    chk("b_err_ovf", 32'(eo_b), 32'(fb.eo));
`ifdef FRAME_CAPTURE_SUM_EN
                    chk("b_frame_sum", sum_b, fb.sum);
`endif
                end
            end
        end
    end

    task automatic do_arm_a();
        arm_a = 1'b1;
        cyc();
        arm_a = 1'b0;
        cyc();
    endtask

    // One frame on instance A: first line bw0 beats, later lines bwn beats, dval high throughout lval.
    task automatic frame_a(input int nl, input int bw0, input int bwn, input bit cap, input int mode,
                           input logic [15:0] ew, input logic [15:0] eh, input bit el, input bit eo,
                           input logic [31:0] es, input bit drop_cont);
        wr_t w;
        fr_t f;
        bus_a.fval = 1'b1;
        bus_a.lval = 1'b0;
        bus_a.dval = 1'b0;
        cyc();
        for (int l = 0; l < nl; l++) begin
            bus_a.lval = 1'b1;
            bus_a.dval = 1'b1;
            for (int b = 0; b < ((l == 0) ? bw0 : bwn); b++) begin
                bus_a.pix_data = pv(mode, l, b);
                if (cap && b < 8 && l < 4) begin
                    w.addr = 32'(l * 8 + b);
                    w.data = 32'(pv(mode, l, b));
                    wq_a.push_back(w);
                end
                cyc();
            end
            bus_a.lval = 1'b0;
            bus_a.dval = 1'b0;
            bus_a.pix_data = 8'hEE;
            cyc();
            if (drop_cont && l == 0) cont_a = 1'b0;
        end
        if (cap) begin
            f.w = ew; f.h = eh; f.el = el; f.eo = eo; f.sum = es;
            fq_a.push_back(f);
        end
        bus_a.fval = 1'b0;
        cyc();
        chk("a_frame_done_pulse", 32'(fd_a), 32'(cap));
    endtask

    // Instance B: 2 lines, lval 8 cycles each, dval on even cycles -> 4 beats of 2 pixels.
    task automatic frame_b();
        wr_t w;
        fr_t f;
        logic [15:0] d;
        bus_b.fval = 1'b1;
        cyc();
        for (int l = 0; l < 2; l++) begin
            bus_b.lval = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (k % 2 == 0) begin
                    d = {8'(l * 16 + k + 2), 8'(l * 16 + k + 1)};
                    bus_b.dval = 1'b1;
                    bus_b.pix_data = d;
                    w.addr = 32'(l * 4 + k / 2);
                    w.data = 32'(d);
                    wq_b.push_back(w);
                end else begin
                    bus_b.dval = 1'b0;
                    bus_b.pix_data = 16'hBEEF;
                end
                cyc();
            end
            bus_b.lval = 1'b0;
            bus_b.dval = 1'b0;
            cyc();
        end
        f.w = 16'd8; f.h = 16'd2; f.el = 1'b0; f.eo = 1'b0; f.sum = 32'd200;
        fq_b.push_back(f);
        bus_b.fval = 1'b0;
        cyc();
        chk("b_frame_done_pulse", 32'(fd_b), 32'd1);
    endtask

    int fdc0;
    wr_t wr;

    initial begin
        rst = 1'b1;
        arm_a = 1'b0; cont_a = 1'b0; arm_b = 1'b0; cont_b = 1'b0;
        bus_a.fval = 1'b0; bus_a.lval = 1'b0; bus_a.dval = 1'b0; bus_a.pix_data = '0;
        bus_b.fval = 1'b0; bus_b.lval = 1'b0; bus_b.dval = 1'b0; bus_b.pix_data = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_frame_done", 32'(fd_a), 32'd0);
        chk("rst_meas_width", 32'(mw_a), 32'd0);
        chk("rst_meas_height", 32'(mh_a), 32'd0);
        chk("rst_err_len", 32'(el_a), 32'd0);
        chk("rst_err_ovf", 32'(eo_a), 32'd0);
        chk("rst_mem_we", 32'(bus_a.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
        chk("rst_mem_data", 32'(bus_a.mem_data), 32'd0);
`ifdef FRAME_CAPTURE_SUM_EN
        chk("rst_frame_sum", sum_a, 32'd0);
`endif

        // 4x8 full frame
        do_arm_a();
        chk("a_busy_armed", 32'(busy_a), 32'd1);
        frame_a(4, 8, 8, 1'b1, 0, 16'd8, 16'd4, 1'b0, 1'b0, 32'd912, 1'b0);
        chk("a_busy_after_single", 32'(busy_a), 32'd0);
        cyc();
        chk("a_frame_done_one_cycle", 32'(fd_a), 32'd0);

        // line length mismatch
        do_arm_a();
        frame_a(2, 4, 3, 1'b1, 0, 16'd4, 16'd2, 1'b1, 1'b0, 32'd64, 1'b0);
        cyc();

        // overflow: 6 lines of 10 into an 8x4 window
        do_arm_a();
        frame_a(6, 10, 10, 1'b1, 0, 16'd10, 16'd6, 1'b0, 1'b1, 32'd912, 1'b0);
        cyc();

        // arm while a frame is already running: skipped, next one captured after a 1-cycle gap
        fork
            frame_a(2, 3, 3, 1'b0, 0, 16'd0, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0);
            begin
                repeat (4) cyc();
                arm_a = 1'b1;
                cyc();
                arm_a = 1'b0;
            end
        join
        frame_a(2, 3, 3, 1'b1, 0, 16'd3, 16'd2, 1'b0, 1'b0, 32'd60, 1'b0);
        cyc();

        // continuous mode over 3 frames, cont dropped inside the third
        cont_a = 1'b1;
        cyc();
        cyc();
        fdc0 = fd_count_a;
        frame_a(2, 3, 3, 1'b1, 0, 16'd3, 16'd2, 1'b0, 1'b0, 32'd60, 1'b0);
        frame_a(2, 2, 1, 1'b1, 0, 16'd2, 16'd2, 1'b1, 1'b0, 32'd20, 1'b0);
        frame_a(1, 5, 5, 1'b1, 0, 16'd5, 16'd1, 1'b0, 1'b0, 32'd15, 1'b1);
        chk("a_busy_after_cont", 32'(busy_a), 32'd0);
        cyc();
        chk("a_cont_frame_count", 32'(fd_count_a - fdc0), 32'd3);
        frame_a(1, 2, 2, 1'b0, 0, 16'd0, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        cyc();

        // zero-line frame
        do_arm_a();
        frame_a(0, 0, 0, 1'b1, 0, 16'd0, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        cyc();

        // 2x2 frame of 1,2,3,250
        do_arm_a();
        frame_a(2, 2, 2, 1'b1, 1, 16'd2, 16'd2, 1'b0, 1'b0, 32'd256, 1'b0);
        cyc();

        // CH=2 with dval toggling
        arm_b = 1'b1;
        cyc();
        arm_b = 1'b0;
        cyc();
        frame_b();
        cyc();

        // reset in the middle of a line: third beat's write and the frame_done are dropped
        do_arm_a();
        bus_a.fval = 1'b1;
        cyc();
        bus_a.lval = 1'b1;
        bus_a.dval = 1'b1;
        bus_a.pix_data = 8'h11;
        wr.addr = 32'd0; wr.data = 32'h11;
        wq_a.push_back(wr);
        cyc();
        bus_a.pix_data = 8'h12;
        wr.addr = 32'd1; wr.data = 32'h12;
        wq_a.push_back(wr);
        cyc();
        bus_a.pix_data = 8'h13;
        cyc();
        rst = 1'b1;
        #1;
        chk("midrst_mem_we", 32'(bus_a.mem_we), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        cyc();
        chk("midrst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
        chk("midrst_mem_data", 32'(bus_a.mem_data), 32'd0);
        chk("midrst_meas_width", 32'(mw_a), 32'd0);
`ifdef FRAME_CAPTURE_SUM_EN
        chk("midrst_frame_sum", sum_a, 32'd0);
`endif
        rst = 1'b0;
        bus_a.lval = 1'b0;
        bus_a.dval = 1'b0;
        bus_a.fval = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("midrst_no_frame_done", 32'(fd_a), 32'd0);
        end

        chk("a_writes_drained", 32'(wq_a.size()), 32'd0);
        chk("a_frames_drained", 32'(fq_a.size()), 32'd0);
        chk("b_writes_drained", 32'(wq_b.size()), 32'd0);
        chk("b_frames_drained", 32'(fq_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
